// File: rtl/vga_fb_reader.sv
// Double-buffered 160x120 greyscale framebuffer with 4x4 upscale to 640x480.
// The CPU writes the back bank and requests a swap. The swap is applied only
// at the last active pixel of a frame, so the displayed image never tears.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no swap outstanding, CPU writes accepted
// PENDING | swap requested, waiting for frame end, CPU writes stalled
module vga_fb_reader #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int FB_DEPTH    = 19200,
  parameter int AW          = 15
) (
  input  logic          pclk,
  input  logic          reset_n,
  input  logic [9:0]    h_addr,
  input  logic [9:0]    v_addr,
  input  logic          valid,
  output logic [7:0]    vga_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_err,
  input  logic          swap_req,
  output logic          swap_done,
  output logic          front_sel
);

  localparam logic [0:0]    IDLE    = 1'b0;
  localparam logic [0:0]    PENDING = 1'b1;

  localparam logic [9:0]    H_LAST  = 10'(H_RES - 1);
  localparam logic [9:0]    V_LAST  = 10'(V_RES - 1);
  localparam logic [9:0]    FB_W10  = 10'(FB_W);
  localparam logic [9:0]    FB_H10  = 10'(FB_H);
  localparam logic [AW-1:0] DEPTH   = AW'(FB_DEPTH);

  logic [7:0]    bank0 [FB_DEPTH];
  logic [7:0]    bank1 [FB_DEPTH];

  logic [0:0]    state_q, state_d;
  logic          front_sel_q, front_sel_d;
  logic          swap_done_q;
  logic          wr_err_q;
  logic          rd_en_q;
  logic          rd_sel_q;
  logic [7:0]    rd0_q, rd1_q;

  logic [9:0]    fb_x, fb_y;
  logic [AW-1:0] rd_row, rd_addr, rd_idx;
  logic          in_range, rd_en;
  logic          wr_fire, wr_in_range;
  logic          frame_end, toggle;

  // Scale the display coordinate down to a framebuffer address; *160 as shift-add.
  assign fb_x      = h_addr >> SCALE_SHIFT;
  assign fb_y      = v_addr >> SCALE_SHIFT;
  assign rd_row    = AW'(fb_y);
  assign rd_addr   = (rd_row << 7) + (rd_row << 5) + AW'(fb_x);
  assign in_range  = (fb_x < FB_W10) && (fb_y < FB_H10);
  assign rd_en     = valid && in_range;
  // Keep the array index inside the bank when the coordinate is blank.
  assign rd_idx    = in_range ? rd_addr : '0;

  assign wr_ready    = (state_q == IDLE);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (wr_addr < DEPTH);

  assign frame_end = valid && (h_addr == H_LAST) && (v_addr == V_LAST);

  // Swap FSM: a request either completes on the spot at frame end or waits for it.
  always_comb begin
    state_d     = state_q;
    toggle      = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_req) begin
          if (frame_end) toggle  = 1'b1;
          else           state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_end) begin
          toggle  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    front_sel_d = front_sel_q ^ toggle;
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      swap_done_q <= toggle;
      wr_err_q    <= wr_fire && !wr_in_range;
      rd_en_q     <= rd_en;
      rd_sel_q    <= front_sel_q;
    end
  end

  // Bank storage: back-bank write and read of both banks; contents survive reset.
  always_ff @(posedge pclk) begin
    if (wr_fire && wr_in_range) begin
      if (front_sel_q) bank0[wr_addr] <= wr_data;
      else             bank1[wr_addr] <= wr_data;
    end
    rd0_q <= bank0[rd_idx];
    rd1_q <= bank1[rd_idx];
  end

  // Blank pixels come from the reset-able enable, so reset forces zero immediately.
  assign vga_data  = rd_en_q ? (rd_sel_q ? rd1_q : rd0_q) : 8'h00;
  assign wr_err    = wr_err_q;
  assign swap_done = swap_done_q;
  assign front_sel = front_sel_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: preloads both banks through the write port, runs
// directed swap/read scenarios and a randomized phase against a frame-level
// reference model, then checks an asynchronous reset during a pending swap.
module tb_vga_fb_reader;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic [9:0]  h_addr, v_addr;
  logic        valid;
  logic [7:0]  vga_data;
  logic        wr_valid, wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_err;
  logic        swap_req, swap_done, front_sel;

  vga_fb_reader dut (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .h_addr    (h_addr),
    .v_addr    (v_addr),
    .valid     (valid),
    .vga_data  (vga_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .swap_req  (swap_req),
    .swap_done (swap_done),
    .front_sel (front_sel)
  );

  always #5 pclk = ~pclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: image contents per bank (-1 = never written), displayed
  // bank, and whether a swap is waiting for frame end.
  int bank [2][19200];
  int m_front;
  bit m_pend;
  int e_vga, e_err, e_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    if (e_vga >= 0) check("vga_data", {24'h0, vga_data}, e_vga);
    check("wr_err", {31'h0, wr_err}, e_err);
    check("swap_done", {31'h0, swap_done}, e_done);
    check("front_sel", {31'h0, front_sel}, m_front);
    check("wr_ready", {31'h0, wr_ready}, {31'h0, !m_pend});
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(input int h, input int v, input bit val, input bit wv,
                      input int wa, input int wd, input bit sr);
    bit fire, fe, tog;
    h_addr   = h[9:0];
    v_addr   = v[9:0];
    valid    = val;
    wr_valid = wv;
    wr_addr  = wa[14:0];
    wr_data  = wd[7:0];
    swap_req = sr;

    if (val && h < 640 && v < 480) e_vga = bank[m_front][(v / 4) * 160 + (h / 4)];
    else                           e_vga = 0;
    fire  = wv && !m_pend;
    e_err = (fire && wa >= 19200) ? 1 : 0;
    if (fire && wa < 19200) bank[1 - m_front][wa] = wd;
    fe     = val && h == 639 && v == 479;
    tog    = fe && (m_pend || sr);
    m_pend = !tog && (m_pend || sr);
    if (tog) m_front = 1 - m_front;
    e_done = tog ? 1 : 0;

    @(negedge pclk);
    check_outputs();
  endtask

  task automatic rand_step();
    int r, h, v, wa;
    r = $urandom_range(99);
    if (r < 3) begin
      h = 639; v = 479;
    end else if (r < 12) begin
      h = $urandom_range(1023); v = $urandom_range(1023);
    end else begin
      h = $urandom_range(639); v = $urandom_range(479);
    end
    if ($urandom_range(19) == 0) wa = $urandom_range(32767, 19200);
    else                         wa = $urandom_range(19199);
    step(h, v, $urandom_range(9) < 7, $urandom_range(1) == 1, wa,
         $urandom_range(255), $urandom_range(19) == 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 19200; a++) bank[b][a] = -1;
    m_front = 0; m_pend = 1'b0;
    e_vga = 0; e_err = 0; e_done = 0;

    reset_n = 1'b1;
    h_addr = '0; v_addr = '0; valid = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge pclk);
    check_outputs();
    @(negedge pclk);
    reset_n = 1'b1;

    // Fill bank1, swap at frame end, then fill bank0.
    for (int a = 0; a < 19200; a++) step(0, 0, 1'b0, 1'b1, a, $urandom_range(255), 1'b0);
    step(639, 479, 1'b1, 1'b0, 0, 0, 1'b1);
    for (int a = 0; a < 19200; a++) step(0, 0, 1'b0, 1'b1, a, $urandom_range(255), 1'b0);

    // Known pattern in the back bank, then a mid-frame swap with a repeated request.
    step(0, 0, 1'b1, 1'b1, 0, 8'hAA, 1'b0);
    step(1, 0, 1'b1, 1'b1, 161, 8'h55, 1'b0);
    step(2, 0, 1'b1, 1'b1, 162, 8'h33, 1'b0);
    step(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    step(100, 50, 1'b1, 1'b0, 0, 0, 1'b1);
    step(101, 50, 1'b1, 1'b1, 5, 8'h99, 1'b1);
    step(102, 50, 1'b1, 1'b1, 6, 8'h98, 1'b0);
    step(639, 479, 1'b1, 1'b0, 0, 0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) step(x, y, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int y = 4; y < 8; y++)
      for (int x = 4; x < 8; x++) step(x, y, 1'b1, 1'b0, 0, 0, 1'b0);
    step(8, 4, 1'b1, 1'b0, 0, 0, 1'b0);
    step(8, 4, 1'b0, 1'b0, 0, 0, 1'b0);

    // Blank input ignores coordinates.
    for (int i = 0; i < 10; i++)
      step($urandom_range(1023), $urandom_range(1023), 1'b0, 1'b0, 0, 0, 1'b0);

    // Swap requested exactly at frame end, write on the same cycle.
    step(639, 479, 1'b1, 1'b1, 7, 8'h11, 1'b1);
    step(7 * 4, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    step(639, 479, 1'b1, 1'b0, 0, 0, 1'b0);

    // Out-of-range writes are dropped and flagged.
    step(0, 0, 1'b0, 1'b1, 19200, 8'h77, 1'b0);
    step(0, 0, 1'b0, 1'b1, 32767, 8'h78, 1'b0);
    step(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 15000; i++) rand_step();

    // Asynchronous reset while a swap is pending, with front_sel at 1.
    if (m_pend) step(639, 479, 1'b1, 1'b0, 0, 0, 1'b0);
    if (m_front == 0) step(639, 479, 1'b1, 1'b0, 0, 0, 1'b1);
    step(20, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    step(20, 20, 1'b1, 1'b0, 0, 0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    m_front = 0; m_pend = 1'b0; e_vga = 0; e_err = 0; e_done = 0;
    check_outputs();
    @(negedge pclk);
    check_outputs();
    reset_n = 1'b1;

    for (int i = 0; i < 300; i++) rand_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
